lane_load_gather: RTL and testbench



---
 rtl/lane_load_gather.sv | 204 ++++++++++++++++++++
 tb/tb_lane_load_gather.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_load_gather.sv
// rtl/lane_load_gather.sv - gathers lane-serial load responses into one vector register writeback
//
// Collects per-lane load responses (one lane per cycle, any order) into a full
// NUM_LANES-wide vector. Once every lane named in the request mask has returned,
// it issues a single writeback to the vector register file.
//
// Optional feature macro: LOAD_GATHER_TIMEOUT_EN
//   defined   : a watchdog retires a stalled gather after TIMEOUT_CYCLES idle
//               COLLECT cycles. Only the lanes received so far are marked valid.
//   undefined : no watchdog is built, err_timeout is tied to 0, and COLLECT
//               waits indefinitely.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   start_valid/ready           gather request handshake
//   start_mask, start_rd        lanes expected to return data; destination register
//   resp_valid/ready            lane response handshake (ready only in COLLECT)
//   resp_lane, resp_data        lane index and load data of the response
//   wb_valid/ready              register file writeback handshake
//   wb_rd, wb_mask, wb_data     writeback register, valid lanes, packed lane data
//                               (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
//   busy                        high whenever not IDLE
//   err_unexp                   1-cycle pulse: response for a non-pending lane
//   err_timeout                 1-cycle pulse: watchdog retired the gather

module lane_load_gather #(
    parameter int NUM_LANES      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_IDX_W      = 5,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int LANE_W        = $clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [NUM_LANES-1:0]            start_mask,
    input  logic [REG_IDX_W-1:0]            start_rd,
    input  logic                            resp_valid,
    output logic                            resp_ready,
    input  logic [LANE_W-1:0]               resp_lane,
    input  logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [REG_IDX_W-1:0]            wb_rd,
    output logic [NUM_LANES-1:0]            wb_mask,
    output logic [NUM_LANES*DATA_WIDTH-1:0] wb_data,
    output logic                            busy,
    output logic                            err_unexp,
    output logic                            err_timeout
);

    // Elaboration-time parameter sanity checks.
    if ((NUM_LANES < 2) || ((NUM_LANES & (NUM_LANES - 1)) != 0)) begin : g_bad_lanes
        $error("lane_load_gather: NUM_LANES must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lane_load_gather: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_WRITEBACK = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_LANES-1:0]    pending_q, pending_d;
    logic [NUM_LANES-1:0]    mask_q, mask_d;
    logic [REG_IDX_W-1:0]    rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   data_q [NUM_LANES];
    logic [DATA_WIDTH-1:0]   data_d [NUM_LANES];
    logic                    err_unexp_q, err_unexp_d;
    logic [NUM_LANES-1:0]    lane_oh;
    logic                    lane_hit;

`ifdef LOAD_GATHER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_timeout_q, err_timeout_d;
`endif

    // One-hot of the responding lane, and whether that lane is still owed.
    always_comb begin
        lane_oh            = '0;
        lane_oh[resp_lane] = 1'b1;
        lane_hit           = |(pending_q & lane_oh);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        mask_d      = mask_q;
        rd_d        = rd_q;
        data_d      = data_q;
        err_unexp_d = 1'b0;
`ifdef LOAD_GATHER_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    pending_d = start_mask;
                    mask_d    = start_mask;
                    rd_d      = start_rd;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        data_d[i] = '0;
                    end
`ifdef LOAD_GATHER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    // An empty mask has nothing to collect: retire immediately.
                    state_d = (start_mask == '0) ? ST_WRITEBACK : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (resp_valid) begin
                    if (lane_hit) begin
                        data_d[resp_lane]    = resp_data;
                        pending_d[resp_lane] = 1'b0;
                        if ((pending_q & ~lane_oh) == '0) begin
                            state_d = ST_WRITEBACK;
                        end
                    end else begin
                        // Duplicate or unmasked lane: consumed, data dropped.
                        err_unexp_d = 1'b1;
                    end
`ifdef LOAD_GATHER_TIMEOUT_EN
                    // Any consumed response counts as progress, so a response
                    // arriving on the timeout cycle always wins.
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_WRITEBACK;
                    mask_d        = mask_q & ~pending_q;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_WRITEBACK: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            mask_q      <= '0;
            rd_q        <= '0;
            err_unexp_q <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                data_q[i] <= '0;
            end
`ifdef LOAD_GATHER_TIMEOUT_EN
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            rd_q        <= rd_d;
            err_unexp_q <= err_unexp_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                data_q[i] <= data_d[i];
            end
`ifdef LOAD_GATHER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign resp_ready  = (state_q == ST_COLLECT);
    assign wb_valid    = (state_q == ST_WRITEBACK);
    assign busy        = (state_q != ST_IDLE);
    assign err_unexp   = err_unexp_q;

`ifdef LOAD_GATHER_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Writeback fields are held in registers, so they stay stable under
    // backpressure. They are gated to 0 when no writeback is offered.
    assign wb_rd   = wb_valid ? rd_q : '0;
    assign wb_mask = wb_valid ? mask_q : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
        assign wb_data[g*DATA_WIDTH +: DATA_WIDTH] = wb_valid ? data_q[g] : '0;
    end

endmodule

// File: tb/tb_lane_load_gather.sv
// tb/tb_lane_load_gather.sv - self-checking bench for lane_load_gather

module tb_lane_load_gather;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int RW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_valid;
    logic               start_ready;
    logic [NL-1:0]      start_mask;
    logic [RW-1:0]      start_rd;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_lane;
    logic [DW-1:0]      resp_data;
    logic               wb_valid;
    logic               wb_ready;
    logic [RW-1:0]      wb_rd;
    logic [NL-1:0]      wb_mask;
    logic [NL*DW-1:0]   wb_data;
    logic               busy;
    logic               err_unexp;
    logic               err_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lane_load_gather #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .REG_IDX_W(RW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_mask(start_mask), .start_rd(start_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_lane(resp_lane), .resp_data(resp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_data(wb_data),
        .busy(busy), .err_unexp(err_unexp), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic [3:0]      mask;
        logic [4:0]      rd;
        int              n;
        logic [3:0][1:0] lane;
        logic [3:0][7:0] data;
        logic [31:0]     exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [4:0] r);
        start_valid = 1'b1;
        start_mask  = m;
        start_rd    = r;
        tick();
        start_valid = 1'b0;
        start_mask  = '0;
        start_rd    = '0;
    endtask

    task automatic do_resp(input logic [1:0] l, input logic [7:0] d);
        resp_valid = 1'b1;
        resp_lane  = l;
        resp_data  = d;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic retire(input string name);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({name, "_start_ready"}, start_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_wb_valid"}, wb_valid, 0);
    endtask

    initial begin
        int pulses;
        int hit_cycle;
        logic saw_to, saw_wb;
        logic [3:0] mask_at_to;

        vecs[0] = '{mask: 4'b1111, rd: 5'd7, n: 4,
                    lane: {2'd1, 2'd2, 2'd0, 2'd3},
                    data: {8'h0B, 8'h0C, 8'h0A, 8'h0D}, exp_data: 32'h0D0C0B0A};
        vecs[1] = '{mask: 4'b1000, rd: 5'd31, n: 1,
                    lane: {2'd0, 2'd0, 2'd0, 2'd3},
                    data: {8'h00, 8'h00, 8'h00, 8'hFF}, exp_data: 32'hFF000000};
        vecs[2] = '{mask: 4'b0110, rd: 5'd1, n: 2,
                    lane: {2'd0, 2'd0, 2'd1, 2'd2},
                    data: {8'h00, 8'h00, 8'hA5, 8'h5A}, exp_data: 32'h005AA500};
        vecs[3] = '{mask: 4'b1111, rd: 5'd0, n: 4,
                    lane: {2'd3, 2'd2, 2'd1, 2'd0},
                    data: {8'h04, 8'h03, 8'h02, 8'h01}, exp_data: 32'h04030201};

        rst = 1'b1; start_valid = 1'b0; start_mask = '0; start_rd = '0;
        resp_valid = 1'b0; resp_lane = '0; resp_data = '0; wb_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_mask", wb_mask, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_err_unexp", err_unexp, 0);
        chk("rst_err_timeout", err_timeout, 0);

        // Table-driven gathers (vector 0 is the out-of-order full gather)
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].mask, vecs[v].rd);
            chk($sformatf("v%0d_busy", v), busy, 1);
            chk($sformatf("v%0d_resp_ready", v), resp_ready, 1);
            for (int k = 0; k < vecs[v].n; k++) begin
                chk($sformatf("v%0d_pre_wb_valid%0d", v, k), wb_valid, 0);
                do_resp(vecs[v].lane[k], vecs[v].data[k]);
            end
            chk($sformatf("v%0d_wb_valid", v), wb_valid, 1);
            chk($sformatf("v%0d_wb_data", v), wb_data, vecs[v].exp_data);
            chk($sformatf("v%0d_wb_mask", v), wb_mask, vecs[v].mask);
            chk($sformatf("v%0d_wb_rd", v), wb_rd, vecs[v].rd);
            chk($sformatf("v%0d_resp_ready_wb", v), resp_ready, 0);
            chk($sformatf("v%0d_start_ready_wb", v), start_ready, 0);
            retire($sformatf("v%0d", v));
        end

        // Writeback backpressure holds outputs stable
        do_start(4'b0101, 5'd9);
        do_resp(2'd0, 8'h11);
        do_resp(2'd2, 8'h22);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_wb_valid%0d", c), wb_valid, 1);
            chk($sformatf("bp_wb_data%0d", c), wb_data, 32'h00220011);
            chk($sformatf("bp_wb_mask%0d", c), wb_mask, 4'b0101);
            chk($sformatf("bp_wb_rd%0d", c), wb_rd, 5'd9);
            tick();
        end
        retire("bp");

        // Duplicate and unmasked responses
        pulses = 0;
        do_start(4'b0011, 5'd2);
        do_resp(2'd0, 8'h33);
        chk("dup_err0", err_unexp, 0);
        do_resp(2'd0, 8'h44);
        pulses += int'(err_unexp);
        chk("dup_err1", err_unexp, 1);
        do_resp(2'd3, 8'h55);
        pulses += int'(err_unexp);
        chk("dup_err2", err_unexp, 1);
        chk("dup_busy", busy, 1);
        chk("dup_no_wb", wb_valid, 0);
        do_resp(2'd1, 8'h66);
        pulses += int'(err_unexp);
        chk("dup_err3", err_unexp, 0);
        chk("dup_pulses", pulses, 2);
        chk("dup_wb_valid", wb_valid, 1);
        chk("dup_wb_data", wb_data, 32'h00006633);
        chk("dup_wb_mask", wb_mask, 4'b0011);
        retire("dup");

        // Empty-mask retire, and no response accepted in WRITEBACK
        do_start(4'b0000, 5'd3);
        resp_valid = 1'b1; resp_lane = 2'd1; resp_data = 8'hEE;
        chk("empty_wb_valid", wb_valid, 1);
        chk("empty_wb_mask", wb_mask, 0);
        chk("empty_wb_data", wb_data, 0);
        chk("empty_wb_rd", wb_rd, 5'd3);
        chk("empty_resp_ready", resp_ready, 0);
        resp_valid = 1'b0;
        retire("empty");
        chk("empty_idle_resp_ready", resp_ready, 0);

        // Reset mid-gather
        do_start(4'b1111, 5'd4);
        do_resp(2'd1, 8'h77);
        do_resp(2'd2, 8'h88);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_resp_ready", resp_ready, 0);
        do_start(4'b1001, 5'd6);
        do_resp(2'd0, 8'h01);
        do_resp(2'd3, 8'h02);
        chk("midrst_wb_valid2", wb_valid, 1);
        chk("midrst_wb_data", wb_data, 32'h02000001);
        chk("midrst_wb_mask", wb_mask, 4'b1001);
        chk("midrst_wb_rd", wb_rd, 5'd6);
        retire("midrst");

        // Stalled gather: only lane 0 answers
        do_start(4'b1111, 5'd8);
        do_resp(2'd0, 8'h99);
        saw_to = 1'b0; saw_wb = 1'b0; hit_cycle = -1; mask_at_to = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (err_timeout && !saw_to) begin
                hit_cycle  = c;
                mask_at_to = wb_mask;
            end
            saw_to |= err_timeout;
            saw_wb |= wb_valid;
        end
`ifdef LOAD_GATHER_TIMEOUT_EN
        chk("to_cycle", hit_cycle, 8);
        chk("to_mask", mask_at_to, 4'b0001);
        chk("to_wb_data", wb_data, 32'h00000099);
        chk("to_wb_valid", wb_valid, 1);
        retire("to");
`else
        chk("to_no_timeout", saw_to, 0);
        chk("to_no_wb", saw_wb, 0);
        chk("to_hit_cycle", hit_cycle, -1);
        chk("to_still_busy", busy, 1);
        chk("to_resp_ready", resp_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_rst_idle", start_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
